// File: rtl/dragonfang_pkg.sv
// Shared vector-datapath types: element-width, sign and divide-mode encodings,
// the execution control bundle, the divider state enum and width helpers.
package dragonfang_pkg;

    typedef enum logic [2:0] {
        ENABLED_8BIT_MODE  = 3'd0,
        ENABLED_16BIT_MODE = 3'd1,
        ENABLED_32BIT_MODE = 3'd2,
        ENABLED_64BIT_MODE = 3'd3
    } bit_mode_t;

    typedef enum logic [1:0] {
        ENABLED_UNSIGNED_UNSIGNED_MODE = 2'd0,
        ENABLED_SIGNED_UNSIGNED_MODE   = 2'd1,
        ENABLED_SIGNED_SIGNED_MODE     = 2'd2
    } sign_mode_t;

    typedef enum logic {
        DIV_QUOTIENT_MODE  = 1'b0,
        DIV_REMAINDER_MODE = 1'b1
    } div_mode_t;

    typedef struct packed {
        bit_mode_t  bit_mode;
        sign_mode_t sign_mode;
        div_mode_t  div_mode;
    } execution_vector_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } division_state_t;

    // Unknown bit_mode encodings fall back to a single 64-bit lane.
    function automatic logic [6:0] sew_of(input bit_mode_t mode);
        case (mode)
            ENABLED_8BIT_MODE:  return 7'd8;
            ENABLED_16BIT_MODE: return 7'd16;
            ENABLED_32BIT_MODE: return 7'd32;
            default:            return 7'd64;
        endcase
    endfunction

    function automatic logic [63:0] sew_mask(input logic [6:0] sew);
        return (sew >= 7'd64) ? '1 : ((64'd1 << sew) - 64'd1);
    endfunction

endpackage

// File: rtl/division_lane_step.sv
// One restoring shift-subtract step for a single lane slot. The slot is 64 bits
// wide; only the low SEW bits carry data.
module division_lane_step
    import dragonfang_pkg::*;
(
    input  logic [6:0]  sew,
    input  logic [63:0] divisor,
    input  logic [63:0] rem,
    input  logic [63:0] quo,
    output logic [63:0] rem_next,
    output logic [63:0] quo_next
);

    logic [63:0] mask;
    logic        dividend_bit;
    logic [64:0] trial;
    logic [64:0] diff;
    logic        quo_bit;

    // quo starts as the dividend magnitude: its top bit shifts into the
    // partial remainder while the new quotient bit enters at the bottom.
    always_comb begin
        mask         = sew_mask(sew);
        dividend_bit = quo[6'(sew - 7'd1)];
        trial        = {rem, dividend_bit};
        diff         = trial - {1'b0, divisor};
        quo_bit      = ~diff[64];
        rem_next     = quo_bit ? diff[63:0] : trial[63:0];
        quo_next     = {quo[62:0], quo_bit} & mask;
    end

endmodule

// File: rtl/vector_division_unit.sv
// Iterative packed-SIMD integer divider/remainder (8/16/32/64-bit lanes).
// Optional macro VECTOR_DIVISION_EARLY_OUT_EN skips the iteration phase when no lane needs it.
module vector_division_unit
    import dragonfang_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_LANES  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  execution_vector_t     execution_vector,
    input  logic [DATA_WIDTH-1:0] vs2,
    input  logic [DATA_WIDTH-1:0] vs1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] vd
);

    division_state_t state;
    logic [5:0]      count;
    logic            accept;
    logic            take_early;

    logic [6:0]      cap_sew;
    logic [5:0]      cap_msb;
    logic [63:0]     cap_mask;
    logic            cap_signed;

    logic [6:0]      sew_q;
    logic            signed_q;
    div_mode_t       div_mode_q;
    logic [63:0]     dvd_q;
    logic [63:0]     dvs_q;

    logic [5:0]      fix_msb;
    logic [63:0]     fix_mask;
    logic [63:0]     fix_min;
    logic [MAX_LANES-1:0][63:0] fix_lane;
    logic [63:0]     fix_vd;

    assign accept     = in_valid && in_ready;
    assign in_ready   = (state == IDLE);

    assign cap_sew    = sew_of(execution_vector.bit_mode);
    assign cap_msb    = 6'(cap_sew - 7'd1);
    assign cap_mask   = sew_mask(cap_sew);
    assign cap_signed = (execution_vector.sign_mode == ENABLED_SIGNED_SIGNED_MODE);

    assign fix_msb    = 6'(sew_q - 7'd1);
    assign fix_mask   = sew_mask(sew_q);
    assign fix_min    = 64'd1 << fix_msb;

`ifdef VECTOR_DIVISION_EARLY_OUT_EN
    logic [MAX_LANES-1:0] lane_needs_busy;
    assign take_early = ~|lane_needs_busy;
`else
    assign take_early = 1'b0;
`endif

    for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
        logic [9:0]  cap_shamt;
        logic [63:0] cap_dvd;
        logic [63:0] cap_dvs;
        logic        cap_neg_dvd;
        logic        cap_neg_dvs;
        logic [63:0] cap_mag_dvd;
        logic [63:0] cap_mag_dvs;

        logic [63:0] rem_q;
        logic [63:0] quo_q;
        logic [63:0] mag_dvs_q;
        logic        neg_dvd_q;
        logic        neg_dvs_q;
        logic [63:0] rem_next;
        logic [63:0] quo_next;

        logic [9:0]  fix_shamt;
        logic [63:0] fix_dvd;
        logic [63:0] fix_dvs;
        logic [63:0] fix_quo;
        logic [63:0] fix_rem;
        logic [63:0] fix_res;

        assign cap_shamt   = 10'(g) * 10'(cap_sew);
        assign cap_dvd     = (vs2 >> cap_shamt) & cap_mask;
        assign cap_dvs     = (vs1 >> cap_shamt) & cap_mask;
        assign cap_neg_dvd = cap_signed & cap_dvd[cap_msb];
        assign cap_neg_dvs = cap_signed & cap_dvs[cap_msb];
        assign cap_mag_dvd = cap_neg_dvd ? ((~cap_dvd + 64'd1) & cap_mask) : cap_dvd;
        assign cap_mag_dvs = cap_neg_dvs ? ((~cap_dvs + 64'd1) & cap_mask) : cap_dvs;

`ifdef VECTOR_DIVISION_EARLY_OUT_EN
        assign lane_needs_busy[g] = (cap_shamt < 10'd64) && (cap_dvs != '0) &&
                                    (cap_mag_dvd >= cap_mag_dvs);
`endif

        // NOTE: the per-lane datapath registers have no reset; every field is
        // written at accept before anything reads it, so a reset would only cost area.
        always_ff @(posedge clk) begin
            if (accept) begin
                rem_q     <= take_early ? cap_mag_dvd : '0;
                quo_q     <= take_early ? '0 : cap_mag_dvd;
                mag_dvs_q <= cap_mag_dvs;
                neg_dvd_q <= cap_neg_dvd;
                neg_dvs_q <= cap_neg_dvs;
            end else if (state == BUSY) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
            end
        end

        division_lane_step u_step (
            .sew      (sew_q),
            .divisor  (mag_dvs_q),
            .rem      (rem_q),
            .quo      (quo_q),
            .rem_next (rem_next),
            .quo_next (quo_next)
        );

        assign fix_shamt = 10'(g) * 10'(sew_q);
        assign fix_dvd   = (dvd_q >> fix_shamt) & fix_mask;
        assign fix_dvs   = (dvs_q >> fix_shamt) & fix_mask;

        // NOTE: fix_quo/fix_rem receive a full default before the special cases
        // override them, so no path leaves them unassigned and no latch forms.
        always_comb begin
            fix_quo = (neg_dvd_q ^ neg_dvs_q) ? ((~quo_q + 64'd1) & fix_mask) : quo_q;
            fix_rem = neg_dvd_q ? ((~rem_q + 64'd1) & fix_mask) : rem_q;
            if (fix_dvs == '0) begin
                fix_quo = fix_mask;
                fix_rem = fix_dvd;
            end else if (signed_q && (fix_dvd == fix_min) && (fix_dvs == fix_mask)) begin
                fix_quo = fix_dvd;
                fix_rem = '0;
            end
            fix_res = (div_mode_q == DIV_REMAINDER_MODE) ? fix_rem : fix_quo;
        end

        assign fix_lane[g] = (fix_shamt < 10'd64) ? (fix_res << fix_shamt) : '0;
    end

    always_comb begin
        fix_vd = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            fix_vd = fix_vd | fix_lane[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sew_q      <= cap_sew;
            signed_q   <= cap_signed;
            div_mode_q <= execution_vector.div_mode;
            dvd_q      <= vs2;
            dvs_q      <= vs1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            vd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= 6'(cap_sew - 7'd1);
                        state <= take_early ? FIXUP : BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state <= FIXUP;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                FIXUP: begin
                    vd        <= fix_vd;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
